// File: rtl/fft_butterfly_7.sv
// -----------------------------------------------------------------------------
// fft_butterfly_7
//   Radix-2 decimation-in-time butterfly with an external 8-entry twiddle
//   table and a 3-stage valid/ready pipeline.
//     X = A + W*B,  Y = A - W*B,  W from the table in signed Q7 (127 = +1.0)
//
//   Optional build macro:
//     FFT_BFLY_SAT_EN  - saturate each X/Y component to DATA_W bits
//                        (default: keep the low DATA_W bits, two's-complement wrap)
//
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     in_valid, in_ready    upstream handshake (in_ready = advance)
//     in_k                  twiddle index for the operand set
//     a_re, a_im, b_re, b_im  signed operands A and B
//     tw_index              index presented to the twiddle table
//     tw_re, tw_im          signed Q7 twiddle returned for tw_index
//     out_valid, out_ready  downstream handshake
//     x_re, x_im, y_re, y_im  signed results X and Y
// -----------------------------------------------------------------------------
module fft_butterfly_7 #(
   parameter int DATA_W = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_k,
   input  logic signed [DATA_W-1:0] a_re,
   input  logic signed [DATA_W-1:0] a_im,
   input  logic signed [DATA_W-1:0] b_re,
   input  logic signed [DATA_W-1:0] b_im,
   output logic [2:0]               tw_index,
   input  logic signed [11:0]       tw_re,
   input  logic signed [11:0]       tw_im,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] x_re,
   output logic signed [DATA_W-1:0] x_im,
   output logic signed [DATA_W-1:0] y_re,
   output logic signed [DATA_W-1:0] y_im
);

   localparam int PW = DATA_W + 12;  // product width
   localparam int TW = DATA_W + 13;  // W*B sum width
   localparam int SW = DATA_W + 14;  // A +/- t width

   function automatic logic signed [PW-1:0] mul_tw(input logic signed [DATA_W-1:0] d,
                                                   input logic signed [11:0] c);
      logic signed [PW-1:0] de;
      logic signed [PW-1:0] ce;
      de = $signed({{12{d[DATA_W-1]}}, d});
      ce = $signed({{DATA_W{c[11]}}, c});
      return de * ce;
   endfunction

   function automatic logic signed [TW-1:0] ext_prod(input logic signed [PW-1:0] v);
      return $signed({v[PW-1], v});
   endfunction

   function automatic logic signed [SW-1:0] ext_a(input logic signed [DATA_W-1:0] v);
      return $signed({{(SW-DATA_W){v[DATA_W-1]}}, v});
   endfunction

   function automatic logic signed [SW-1:0] ext_t(input logic signed [TW-1:0] v);
      return $signed({v[TW-1], v});
   endfunction

   // Reduce a full-width sum to DATA_W bits.
   function automatic logic signed [DATA_W-1:0] reduce_dw(input logic signed [SW-1:0] v);
`ifdef FFT_BFLY_SAT_EN
      // In range only when every bit above the result sign bit matches it.
      if (v[SW-1:DATA_W-1] == {(SW-DATA_W+1){v[SW-1]}})
         return v[DATA_W-1:0];
      else if (v[SW-1])
         return {1'b1, {(DATA_W-1){1'b0}}};
      else
         return {1'b0, {(DATA_W-1){1'b1}}};
`else
      return v[DATA_W-1:0];
`endif
   endfunction

   logic                     advance;
   logic                     vld_p0, vld_p1;
   logic [2:0]               k_p0;
   logic signed [DATA_W-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0;
   logic signed [DATA_W-1:0] a_re_p1, a_im_p1;
   logic signed [PW-1:0]     prod_rr_p1, prod_ii_p1, prod_ri_p1, prod_ir_p1;
   logic signed [TW-1:0]     t_re_full, t_im_full, t_re, t_im;
   logic signed [SW-1:0]     x_re_full, x_im_full, y_re_full, y_im_full;

   // A stalled output freezes the whole pipeline, so upstream sees the same gate.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // The table is addressed straight from S1 so its answer is ready for S2.
   assign tw_index = k_p0;

   assign t_re_full = ext_prod(prod_rr_p1) - ext_prod(prod_ii_p1);
   assign t_im_full = ext_prod(prod_ri_p1) + ext_prod(prod_ir_p1);
   assign t_re      = t_re_full >>> 7;
   assign t_im      = t_im_full >>> 7;

   assign x_re_full = ext_a(a_re_p1) + ext_t(t_re);
   assign x_im_full = ext_a(a_im_p1) + ext_t(t_im);
   assign y_re_full = ext_a(a_re_p1) - ext_t(t_re);
   assign y_im_full = ext_a(a_im_p1) - ext_t(t_im);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0     <= 1'b0;
         vld_p1     <= 1'b0;
         out_valid  <= 1'b0;
         k_p0       <= '0;
         a_re_p0    <= '0;
         a_im_p0    <= '0;
         b_re_p0    <= '0;
         b_im_p0    <= '0;
         a_re_p1    <= '0;
         a_im_p1    <= '0;
         prod_rr_p1 <= '0;
         prod_ii_p1 <= '0;
         prod_ri_p1 <= '0;
         prod_ir_p1 <= '0;
         x_re       <= '0;
         x_im       <= '0;
         y_re       <= '0;
         y_im       <= '0;
      end else if (advance) begin
         // S1: operands and twiddle index
         vld_p0     <= in_valid;
         k_p0       <= in_k;
         a_re_p0    <= a_re;
         a_im_p0    <= a_im;
         b_re_p0    <= b_re;
         b_im_p0    <= b_im;
         // S2: A and the four partial products
         vld_p1     <= vld_p0;
         a_re_p1    <= a_re_p0;
         a_im_p1    <= a_im_p0;
         prod_rr_p1 <= mul_tw(b_re_p0, tw_re);
         prod_ii_p1 <= mul_tw(b_im_p0, tw_im);
         prod_ri_p1 <= mul_tw(b_re_p0, tw_im);
         prod_ir_p1 <= mul_tw(b_im_p0, tw_re);
         // S3: butterfly outputs
         out_valid  <= vld_p1;
         x_re       <= reduce_dw(x_re_full);
         x_im       <= reduce_dw(x_im_full);
         y_re       <= reduce_dw(y_re_full);
         y_im       <= reduce_dw(y_im_full);
      end
   end

endmodule
